// File: rtl/pipe_stage_fifo_pkg.sv
// pipe_pkg: shared pipeline-stage constants, control bundle and NOP payload helper
package pipe_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef struct packed {
      logic       reg_write_enable;
      logic       mem_or_reg;
      logic       pc_or_mem;
      logic       jump;
      logic       jump_register;
      logic       should_branch;
      logic       float_reg_write_enable;
      logic       regfile_mux;
      logic       fp_regfile_mux;
      logic [4:0] alu_operation;
      logic [4:0] rd_num;
   } stage_ctrl_t;

   // The instruction word sits in the low bits; every control bit above it stays clear.
   function automatic logic [1023:0] nop_payload(input int width);
      return (width >= 32) ? {992'b0, NOP_INST} : '0;
   endfunction

endpackage

// File: rtl/pipe_stage_fifo_if.sv
// pipe_stage_fifo_if: valid/ready handshake bundle between two pipeline stages
interface pipe_stage_fifo_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
);
   logic                         in_valid;
   logic [DATA_W-1:0]            in_data;
   logic                         in_ready;
   logic                         out_valid;
   logic [DATA_W-1:0]            out_data;
   logic                         out_ready;
   logic                         stall;
   logic                         flush;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output in_valid, in_data, out_ready, stall, flush,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, out_ready, stall, flush,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/pipe_stage_fifo_ptr_ctr.sv
// pipe_ptr_ctr: wrap-around FIFO pointer with increment enable and synchronous clear
module pipe_ptr_ctr #(
   parameter int DEPTH = 2,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   // Clear beats increment; the last slot wraps back to zero.
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) ptr <= '0;
      else ptr <= clr ? '0 : inc ? ((ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1)) : ptr;

endmodule

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic DEPTH-entry pipeline-stage buffer with stall, flush and NOP bubbles
module pipe_stage_fifo
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 2,
   parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(nop_payload(DATA_W))
) (
   input logic               clk,
   input logic               rst_b,
   pipe_stage_fifo_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              push, pop;

   // Occupancy alone decides full/empty, so the pointers may freely coincide.
   assign bus.in_ready  = (count != CW'(DEPTH)) & ~bus.flush;
   assign bus.out_valid = (count != '0) & ~bus.stall & ~bus.flush;
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : NOP_VALUE;
   assign bus.count     = count;
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   pipe_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk(clk), .rst_b(rst_b), .clr(bus.flush), .inc(push), .ptr(wr_ptr)
   );

   pipe_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk(clk), .rst_b(rst_b), .clr(bus.flush), .inc(pop), .ptr(rd_ptr)
   );

   // Payload storage is deliberately left unreset; count gates what is visible.
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.in_data;

   // Occupancy tracks push/pop; flush empties the buffer regardless of traffic.
   always_ff @(posedge clk or posedge rst_b)
      if (rst_b) count <= '0;
      else if (bus.flush) count <= '0;
      else if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);

   occupancy_bound: assert property (@(posedge clk) disable iff (rst_b) count <= CW'(DEPTH));

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: directed and random checks of pipe_stage_fifo against a queue model
module tb_pipe_stage_fifo;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;

   logic clk = 1'b0;
   logic rst_b = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] q [$];

   always #5 clk = ~clk;

   pipe_stage_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   pipe_stage_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_b(rst_b), .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input logic s, input logic f);
      logic ev;
      ev = (q.size() > 0) && !s && !f;
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      chk("in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) && !f));
      chk("out_data", bus.out_data, ev ? q[0] : '0);
   endtask

   // One clock of traffic: drive, check the pre-edge view, then advance the queue model.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic s, input logic f);
      logic push, pop;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      bus.stall     = s;
      bus.flush     = f;
      #1;
      check_outputs(s, f);
      push = v && (q.size() < DEPTH) && !f;
      pop  = (q.size() > 0) && !s && !f && r;
      @(posedge clk);
      if (f) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(d);
      end
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs(1'b0, 1'b0);
      rst_b = 1'b0;
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(1, 32'h11, 1, 0, 0);
      cycle(1, 32'h22, 1, 0, 0);
      cycle(1, 32'h33, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(1, 32'hA, 0, 0, 0);
      cycle(1, 32'hB, 0, 0, 0);
      cycle(1, 32'hC, 0, 0, 0);
      cycle(1, 32'hC, 1, 0, 0);
      cycle(1, 32'hC, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(1, 32'hA, 0, 0, 0);
      cycle(1, 32'hB, 0, 0, 0);
      repeat (3) cycle(0, 0, 1, 1, 0);
      repeat (3) cycle(0, 0, 1, 0, 0);
      cycle(1, 32'h5, 0, 0, 0);
      cycle(1, 32'h6, 1, 0, 1);
      repeat (2) cycle(0, 0, 1, 0, 0);
      cycle(1, 32'h7, 0, 0, 0);
      cycle(1, 32'h8, 1, 1, 1);
      cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 32'h100 + 32'(i), 1, 0, 0);
         cycle(0, 0, 1, 0, 0);
      end
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 19) == 0));
      cycle(0, 0, 1, 0, 1);
      cycle(1, 32'h77, 0, 0, 0);
      #2 rst_b = 1'b1;
      #1;
      q.delete();
      check_outputs(1'b0, 1'b0);
      @(negedge clk);
      rst_b = 1'b0;
      cycle(0, 0, 1, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
